ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl_if.sv | 20 ++
 rtl/ram_ctrl.sv | 143 ++++++++++++++
 tb/tb_ram_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_if.sv
// Memory-stage request/response bundle between the pipeline and ram_ctrl.
// The master (pipeline) drives the request; the slave (controller) returns data and stall.
interface ram_ctrl_if;
    logic [15:0] memAddr_i;
    logic        rMem_i;
    logic        wMem_i;
    logic [15:0] wMemData_i;
    logic [15:0] rData_o;
    logic        stall_request;

    modport master (
        output memAddr_i, rMem_i, wMem_i, wMemData_i,
        input  rData_o, stall_request
    );

    modport slave (
        input  memAddr_i, rMem_i, wMem_i, wMemData_i,
        output rData_o, stall_request
    );
endinterface

// File: rtl/ram_ctrl.sv
// Asynchronous SRAM controller for a pipeline memory stage; freezes the pipe during access.
// Optional macro RAM_WRITE_HOLD_EN adds a one-cycle data/address hold after the write pulse.
module ram_ctrl #(
    parameter int WE_PULSE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    ram_ctrl_if.slave   mem,
    output logic [17:0] ram_addr_o,
    inout  wire  [15:0] ram_data_io,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    typedef enum logic [2:0] {
        IDLE,
        R_ACC,
        W_SETUP,
        W_PULSE,
`ifdef RAM_WRITE_HOLD_EN
        W_HOLD,
`endif
        DONE
    } state_t;

    localparam logic [2:0] PULSE_LAST = 3'(WE_PULSE_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [2:0]  pulse_cnt;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        bus_drive;
    logic        accept;

    assign accept = (state == IDLE) && (mem.rMem_i || mem.wMem_i);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_cnt <= 3'd0;
        end else if (state == W_PULSE && pulse_cnt != PULSE_LAST) begin
            pulse_cnt <= pulse_cnt + 3'd1;
        end else begin
            pulse_cnt <= 3'd0;
        end
    end

    // Address and store data are frozen at acceptance so the pipeline may change them freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
        end else if (accept) begin
            addr_q  <= mem.memAddr_i;
            wdata_q <= mem.wMemData_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 16'h0000;
        end else if (state == R_ACC) begin
            rdata_q <= ram_data_io;
        end
    end

    // Strobes decode straight from the state register, so an async reset releases them at once.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next        = state;
        ram_ce_n          = 1'b1;
        ram_oe_n          = 1'b1;
        ram_we_n          = 1'b1;
        bus_drive         = 1'b0;
        mem.stall_request = 1'b0;

        unique case (state)
            IDLE: begin
                mem.stall_request = mem.rMem_i || mem.wMem_i;
                if (mem.wMem_i) begin
                    state_next = W_SETUP;
                end else if (mem.rMem_i) begin
                    state_next = R_ACC;
                end
            end
            R_ACC: begin
                ram_ce_n          = 1'b0;
                ram_oe_n          = 1'b0;
                mem.stall_request = 1'b1;
                state_next        = DONE;
            end
            W_SETUP: begin
                ram_ce_n          = 1'b0;
                bus_drive         = 1'b1;
                mem.stall_request = 1'b1;
                state_next        = W_PULSE;
            end
            W_PULSE: begin
                ram_ce_n          = 1'b0;
                ram_we_n          = 1'b0;
                bus_drive         = 1'b1;
                mem.stall_request = 1'b1;
                if (pulse_cnt == PULSE_LAST) begin
`ifdef RAM_WRITE_HOLD_EN
                    state_next = W_HOLD;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef RAM_WRITE_HOLD_EN
            W_HOLD: begin
                ram_ce_n          = 1'b0;
                bus_drive         = 1'b1;
                mem.stall_request = 1'b1;
                state_next        = DONE;
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ram_addr_o  = {2'b00, addr_q};
    assign ram_data_io = bus_drive ? wdata_q : 16'bz;
    assign mem.rData_o = rdata_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: SRAM model on the bus, scoreboard of expected load data.
module tb_ram_ctrl;

    localparam int PULSE = 3;
`ifdef RAM_WRITE_HOLD_EN
    localparam int HOLD = 1;
`else
    localparam int HOLD = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] ram_addr;
    wire  [15:0] ram_data;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic        mon_en = 1'b0;

    ram_ctrl_if bus_if ();

    ram_ctrl #(.WE_PULSE_CYCLES(PULSE)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (bus_if.slave),
        .ram_addr_o  (ram_addr),
        .ram_data_io (ram_data),
        .ram_ce_n    (ram_ce_n),
        .ram_oe_n    (ram_oe_n),
        .ram_we_n    (ram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM model: drives on read strobe, stores on write strobe.
    logic [15:0] sram [0:1023];
    logic [15:0] shadow [0:1023];
    logic        model_drv;

    assign model_drv = !ram_ce_n && !ram_oe_n && ram_we_n;
    assign ram_data  = model_drv ? sram[ram_addr[9:0]] : 16'bz;

    always @(posedge clk) begin
        if (!ram_ce_n && !ram_we_n) sram[ram_addr[9:0]] <= ram_data;
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        #3;
        if (mon_en && !rst) check("oe_we_excl", {31'd0, ram_oe_n | ram_we_n}, 32'd1);
    end

    // Call just after a falling edge; returns in the DONE cycle with requests lowered.
    task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, output int stalls, output int we_lo,
                          output int oe_lo);
        bit done = 0;
        stalls = 0; we_lo = 0; oe_lo = 0;
        if (rd && !wr) sb.push_back(shadow[a[9:0]]);
        if (wr) shadow[a[9:0]] = d;
        bus_if.rMem_i = rd; bus_if.wMem_i = wr;
        bus_if.memAddr_i = a; bus_if.wMemData_i = d;
        for (int k = 0; k < 64; k++) begin
            #1;
            if (!bus_if.stall_request) begin
                done = 1;
                break;
            end
            stalls++;
            if (!ram_we_n) we_lo++;
            if (!ram_oe_n) oe_lo++;
            if (k >= 1) begin
                check("addr_stable", {14'd0, ram_addr}, {16'd0, 2'b00, a});
                if (wr) check("wbus", {16'd0, ram_data}, {16'd0, d});
            end
            if (k == 1) begin
                bus_if.memAddr_i  = ~a;
                bus_if.wMemData_i = ~d;
            end
            @(negedge clk);
        end
        check("access_done", {31'd0, done}, 32'd1);
        if (rd && !wr && sb.size() > 0) check("rdata", {16'd0, bus_if.rData_o}, {16'd0, sb.pop_front()});
        bus_if.rMem_i = 1'b0;
        bus_if.wMem_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int st, wl, ol, bad;
        bit found;
        for (int i = 0; i < 1024; i++) begin
            sram[i]   = 16'h0000;
            shadow[i] = 16'h0000;
        end
        sram[10'h123]   = 16'hBEEF;
        shadow[10'h123] = 16'hBEEF;
        bus_if.rMem_i = 1'b0; bus_if.wMem_i = 1'b0;
        bus_if.memAddr_i = 16'h0; bus_if.wMemData_i = 16'h0;

        // Reset state; stall still follows requests while in reset.
        #2;
        check("rst_ce", {31'd0, ram_ce_n}, 32'd1);
        check("rst_oe", {31'd0, ram_oe_n}, 32'd1);
        check("rst_we", {31'd0, ram_we_n}, 32'd1);
        check("rst_addr", {14'd0, ram_addr}, 32'd0);
        check("rst_rdata", {16'd0, bus_if.rData_o}, 32'd0);
        check("rst_stall_idle", {31'd0, bus_if.stall_request}, 32'd0);
        bus_if.rMem_i = 1'b1;
        #1 check("rst_stall_req", {31'd0, bus_if.stall_request}, 32'd1);
        bus_if.rMem_i = 1'b0;
        @(negedge clk); rst = 1'b0; mon_en = 1'b1;

        // Read of preloaded word.
        @(negedge clk); access(1, 0, 16'h0123, 16'h0, st, wl, ol);
        check("rd_stalls", st, 2); check("rd_oe_lo", ol, 1); check("rd_we_lo", wl, 0);

        // Write.
        @(negedge clk); access(0, 1, 16'h0040, 16'h1234, st, wl, ol);
        check("wr_stalls", st, 2 + PULSE + HOLD); check("wr_we_lo", wl, PULSE); check("wr_oe_lo", ol, 0);

        // Request present in DONE is ignored there, then accepted from IDLE.
        bus_if.rMem_i = 1'b1; bus_if.memAddr_i = 16'h0040;
        #1 check("done_no_stall", {31'd0, bus_if.stall_request}, 32'd0);
        @(negedge clk); access(1, 0, 16'h0040, 16'h0, st, wl, ol);
        check("b2b_rd_stalls", st, 2);

        // Simultaneous read+write: write wins, load data untouched.
        @(negedge clk); access(1, 1, 16'h0041, 16'h5678, st, wl, ol);
        check("both_stalls", st, 2 + PULSE + HOLD); check("both_oe_lo", ol, 0);
        check("both_we_lo", wl, PULSE);
        check("both_rdata_kept", {16'd0, bus_if.rData_o}, 32'h1234);
        @(negedge clk); access(1, 0, 16'h0041, 16'h0, st, wl, ol);

        // Reset asserted during the write pulse.
        @(negedge clk);
        bus_if.wMem_i = 1'b1; bus_if.memAddr_i = 16'h0200; bus_if.wMemData_i = 16'hA5A5;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!ram_we_n) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("pulse_seen", {31'd0, found}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_we", {31'd0, ram_we_n}, 32'd1);
        check("mid_rst_ce", {31'd0, ram_ce_n}, 32'd1);
        check("mid_rst_stall", {31'd0, bus_if.stall_request}, 32'd1);
        check("mid_rst_addr", {14'd0, ram_addr}, 32'd0);
        bus_if.wMem_i = 1'b0;
        #1 check("mid_rst_stall_off", {31'd0, bus_if.stall_request}, 32'd0);
        @(negedge clk); rst = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk); #1;
            if (!ram_we_n || !ram_ce_n || bus_if.stall_request) bad++;
        end
        check("no_reissue", bad, 0);
        check("post_rst_rdata", {16'd0, bus_if.rData_o}, 32'd0);

        @(negedge clk); access(1, 0, 16'h0123, 16'h0, st, wl, ol);
        check("rd2_stalls", st, 2);
        check("sb_empty", sb.size(), 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
